regfile_wb_sched: RTL and testbench

- Write-back scheduler and scoreboard for the single-write-port integer register file (x0..x31).
- Shares the one write port among NUM_SRC write-back sources (ALU, load/L2 return, mul/div) using round-robin valid/ready arbitration.
- Drives the register file's regwrite/rd/rd_data inputs from registered outputs.
- Tracks pending destination registers so issue logic can stall on RAW/WAW hazards.

---
 rtl/rv_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 26 ++
 rtl/regfile_wb_sched.sv | 108 ++++++++++
 tb/tb_regfile_wb_sched.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared integer-pipeline constants and helpers for the register-file write-back path.
package rv_pkg;
  localparam int XLEN  = 32;
  localparam int RA_W  = 5;
  localparam int NREGS = 32;
  localparam logic [RA_W-1:0] X0 = 5'd0;

  function automatic logic [5:0] popcount_regs(input logic [NREGS-1:0] v);
    logic [5:0] cnt;
    cnt = 6'd0;
    for (int i = 0; i < NREGS; i++) begin
      cnt = cnt + {5'd0, v[i]};
    end
    return cnt;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping, wins.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  // Rotating priority scan; found_s blocks every request after the first hit.
  always_comb begin
    logic found_s;
    logic hit_s;
    int   idx_s;
    gnt     = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    idx_s   = 0;
    for (int k = 0; k < N; k++) begin
      idx_s      = (int'(ptr) + k) % N;
      hit_s      = req[idx_s] & ~found_s;
      gnt[idx_s] = gnt[idx_s] | hit_s;
      found_s    = found_s | hit_s;
    end
  end
endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: arbitrates NUM_SRC sources onto the single register-file
// write port and keeps the busy scoreboard used for RAW/WAW stalls at issue.
module regfile_wb_sched #(
  parameter int NUM_SRC = 3,
  parameter int XLEN    = rv_pkg::XLEN,
  parameter int RA_W    = rv_pkg::RA_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alloc_valid,
  input  logic [RA_W-1:0]         alloc_rd,
  output logic                    alloc_ready,
  input  logic [NUM_SRC-1:0]      wb_valid,
  input  logic [NUM_SRC*RA_W-1:0] wb_rd,
  input  logic [NUM_SRC*XLEN-1:0] wb_data,
  output logic [NUM_SRC-1:0]      wb_ready,
  output logic                    rf_regwrite,
  output logic [RA_W-1:0]         rf_rd,
  output logic [XLEN-1:0]         rf_rd_data,
  input  logic [RA_W-1:0]         chk_rs1,
  input  logic [RA_W-1:0]         chk_rs2,
  output logic                    busy_rs1,
  output logic                    busy_rs2,
  output logic [5:0]              pend_cnt,
  output logic                    err_spurious
);
  import rv_pkg::*;

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [NREGS-1:0] REG_ONE = {{(NREGS-1){1'b0}}, 1'b1};

  logic [PW-1:0]      rr_ptr_r;
  logic [NREGS-1:0]   busy_r;
  logic [NUM_SRC-1:0] arb_gnt_s;
  logic [NUM_SRC-1:0] gnt_s;
  logic               hs_s;
  logic [RA_W-1:0]    sel_rd_s;
  logic [XLEN-1:0]    sel_data_s;
  logic [PW-1:0]      hs_ptr_s;
  logic [PW-1:0]      nxt_ptr_s;
  logic               alloc_set_s;
  logic [NREGS-1:0]   clr_mask_s;
  logic [NREGS-1:0]   set_mask_s;
  logic [NREGS-1:0]   busy_nxt_s;
  logic               spur_s;

  rr_arbiter #(.N(NUM_SRC), .PW(PW)) u_arb (
    .req (wb_valid),
    .ptr (rr_ptr_r),
    .gnt (arb_gnt_s)
  );

  assign gnt_s    = rst_n ? arb_gnt_s : '0;
  assign wb_ready = gnt_s;

  // Mux the granted source; the grant is one-hot so OR-combining is exact.
  always_comb begin
    hs_s       = 1'b0;
    sel_rd_s   = '0;
    sel_data_s = '0;
    hs_ptr_s   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hs_s       = hs_s | (gnt_s[i] & wb_valid[i]);
      sel_rd_s   = sel_rd_s | ({RA_W{gnt_s[i] & wb_valid[i]}} & wb_rd[i*RA_W +: RA_W]);
      sel_data_s = sel_data_s | ({XLEN{gnt_s[i] & wb_valid[i]}} & wb_data[i*XLEN +: XLEN]);
      hs_ptr_s   = hs_ptr_s | ({PW{gnt_s[i] & wb_valid[i]}} & PW'((i + 1) % NUM_SRC));
    end
    nxt_ptr_s = hs_s ? hs_ptr_s : rr_ptr_r;
  end

  // A reservation on a busy register is still fine when that register retires this cycle.
  assign alloc_ready = rst_n & alloc_valid &
                       ((alloc_rd == X0) | ~busy_r[alloc_rd] |
                        (rf_regwrite & (rf_rd == alloc_rd)));
  assign alloc_set_s = alloc_ready & (alloc_rd != X0);

  assign clr_mask_s = {NREGS{rf_regwrite}} & (REG_ONE << rf_rd);
  assign set_mask_s = {NREGS{alloc_set_s}} & (REG_ONE << alloc_rd);
  assign busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~REG_ONE;

  assign spur_s = hs_s & (sel_rd_s != X0) & ~busy_r[sel_rd_s] &
                  ~(alloc_set_s & (alloc_rd == sel_rd_s));

  assign busy_rs1 = (chk_rs1 != X0) & busy_r[chk_rs1] & ~(rf_regwrite & (rf_rd == chk_rs1));
  assign busy_rs2 = (chk_rs2 != X0) & busy_r[chk_rs2] & ~(rf_regwrite & (rf_rd == chk_rs2));
  assign pend_cnt = popcount_regs(busy_r);

  // Scoreboard, arbitration pointer and registered write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r       <= '0;
      rr_ptr_r     <= '0;
      rf_regwrite  <= 1'b0;
      rf_rd        <= '0;
      rf_rd_data   <= '0;
      err_spurious <= 1'b0;
    end else begin
      busy_r       <= busy_nxt_s;
      rr_ptr_r     <= nxt_ptr_s;
      rf_regwrite  <= hs_s & (sel_rd_s != X0);
      err_spurious <= err_spurious | spur_s;
      if (hs_s) begin
        rf_rd      <= sel_rd_s;
        rf_rd_data <= sel_data_s;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Scoreboard bench for regfile_wb_sched: a reference model predicts grants,
// busy state and register-file writes; expected writes are queued and popped.
module tb_regfile_wb_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic        alloc_ready;
  logic [2:0]  wb_valid;
  logic [14:0] wb_rd;
  logic [95:0] wb_data;
  logic [2:0]  wb_ready;
  logic        rf_regwrite;
  logic [4:0]  rf_rd;
  logic [31:0] rf_rd_data;
  logic [4:0]  chk_rs1, chk_rs2;
  logic        busy_rs1, busy_rs2;
  logic [5:0]  pend_cnt;
  logic        err_spurious;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } sb_t;
  sb_t sb_q[$];

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_busy  = 32'd0;
  int          m_ptr   = 0;
  logic        m_we    = 1'b0;
  logic [4:0]  m_rd    = 5'd0;
  logic        m_err   = 1'b0;
  logic        last_ar;
  logic [2:0]  last_wb_ready;
  logic        last_brs1;

  always #5 clk = ~clk;

  regfile_wb_sched #(.NUM_SRC(3), .XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .rf_regwrite(rf_regwrite), .rf_rd(rf_rd), .rf_rd_data(rf_rd_data),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
    .pend_cnt(pend_cnt), .err_spurious(err_spurious)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_src(input int i, input logic [4:0] rd, input logic [31:0] data);
    wb_rd[i*5 +: 5]    = rd;
    wb_data[i*32 +: 32] = data;
  endtask

  // One clock: check combinational outputs at negedge, advance model, check registered outputs.
  task automatic tick();
    logic [2:0]  g;
    int          gi;
    int          idx;
    logic        hs;
    logic        ar;
    logic [4:0]  hrd;
    logic [31:0] hdata;
    logic        e1, e2;
    sb_t         e;
    @(negedge clk);
    g  = 3'b000;
    gi = 0;
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        idx = (m_ptr + k) % 3;
        if (g == 3'b000 && wb_valid[idx]) begin
          g[idx] = 1'b1;
          gi     = idx;
        end
      end
    end
    ar = rst_n && alloc_valid &&
         (alloc_rd == 5'd0 || !m_busy[alloc_rd] || (m_we && m_rd == alloc_rd));
    e1 = (chk_rs1 != 5'd0) && m_busy[chk_rs1] && !(m_we && m_rd == chk_rs1);
    e2 = (chk_rs2 != 5'd0) && m_busy[chk_rs2] && !(m_we && m_rd == chk_rs2);
    check_eq("wb_ready", {29'd0, wb_ready}, {29'd0, g});
    check_eq("alloc_ready", {31'd0, alloc_ready}, {31'd0, ar});
    check_eq("busy_rs1", {31'd0, busy_rs1}, {31'd0, e1});
    check_eq("busy_rs2", {31'd0, busy_rs2}, {31'd0, e2});
    check_eq("one_hot", $countones(wb_ready) <= 1 ? 32'd1 : 32'd0, 32'd1);
    last_ar       = alloc_ready;
    last_wb_ready = wb_ready;
    last_brs1     = busy_rs1;
    hs    = |(wb_valid & g);
    hrd   = wb_rd[gi*5 +: 5];
    hdata = wb_data[gi*32 +: 32];
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 32'd0; m_ptr = 0; m_we = 1'b0; m_rd = 5'd0; m_err = 1'b0;
      sb_q.delete();
    end else begin
      if (hs && hrd != 5'd0 && !m_busy[hrd] && !(ar && alloc_rd == hrd)) m_err = 1'b1;
      if (m_we) m_busy[m_rd] = 1'b0;
      if (ar && alloc_rd != 5'd0) m_busy[alloc_rd] = 1'b1;
      m_we = hs && (hrd != 5'd0);
      if (hs) begin
        m_rd  = hrd;
        m_ptr = (gi + 1) % 3;
        sb_q.push_back('{we: (hrd != 5'd0), rd: hrd, data: hdata});
      end
    end
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq("rf_regwrite", {31'd0, rf_regwrite}, {31'd0, e.we});
      if (e.we) begin
        check_eq("rf_rd", {27'd0, rf_rd}, {27'd0, e.rd});
        check_eq("rf_rd_data", rf_rd_data, e.data);
      end
    end else begin
      check_eq("rf_regwrite_idle", {31'd0, rf_regwrite}, 32'd0);
    end
    check_eq("pend_cnt", {26'd0, pend_cnt}, 32'($countones(m_busy)));
    check_eq("err_spurious", {31'd0, err_spurious}, {31'd0, m_err});
  endtask

  initial begin
    rst_n = 1'b0; alloc_valid = 1'b0; alloc_rd = 5'd0;
    wb_valid = 3'b000; wb_rd = 15'd0; wb_data = 96'd0;
    chk_rs1 = 5'd0; chk_rs2 = 5'd2;

    // Reset
    tick(); tick();
    check_eq("rst_rf_rd", {27'd0, rf_rd}, 32'd0);
    check_eq("rst_rf_data", rf_rd_data, 32'd0);
    check_eq("rst_pend", {26'd0, pend_cnt}, 32'd0);
    rst_n = 1'b1;

    // Test 1: alloc then write back rd=5
    alloc_valid = 1'b1; alloc_rd = 5'd5; chk_rs1 = 5'd5;
    tick();
    check_eq("t1_alloc_ready", {31'd0, last_ar}, 32'd1);
    check_eq("t1_pend1", {26'd0, pend_cnt}, 32'd1);
    alloc_valid = 1'b0; set_src(0, 5'd5, 32'hDEADBEEF); wb_valid = 3'b001;
    tick();
    check_eq("t1_busy_before", {31'd0, last_brs1}, 32'd1);
    check_eq("t1_we", {31'd0, rf_regwrite}, 32'd1);
    check_eq("t1_rd", {27'd0, rf_rd}, 32'd5);
    check_eq("t1_data", rf_rd_data, 32'hDEADBEEF);
    wb_valid = 3'b000;
    tick();
    check_eq("t1_busy_fwd", {31'd0, last_brs1}, 32'd0);
    check_eq("t1_pend0", {26'd0, pend_cnt}, 32'd0);

    // Test 2: round-robin with three continuously valid sources
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    alloc_valid = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      alloc_rd = 5'(r);
      tick();
    end
    for (int s = 0; s < 3; s++) set_src(s, 5'(s + 1), 32'hA000_0000 + 32'(s));
    wb_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      alloc_valid = (c != 0);
      alloc_rd    = (c == 0) ? 5'd0 : 5'(((c - 1) % 3) + 1);
      tick();
      check_eq("t2_order", {29'd0, last_wb_ready}, 32'd1 << (c % 3));
    end
    wb_valid = 3'b000; alloc_valid = 1'b1; alloc_rd = 5'd3;
    tick();
    alloc_valid = 1'b0;
    check_eq("t2_no_err", {31'd0, err_spurious}, 32'd0);

    // Test 3: WAW stall on rd=7, released by the retiring write
    alloc_valid = 1'b1; alloc_rd = 5'd7;
    tick();
    set_src(0, 5'd7, 32'h0000_0077); wb_valid = 3'b001;
    tick();
    check_eq("t3_stall", {31'd0, last_ar}, 32'd0);
    wb_valid = 3'b000;
    tick();
    check_eq("t3_release", {31'd0, last_ar}, 32'd1);
    alloc_valid = 1'b0; chk_rs1 = 5'd7;
    tick();
    check_eq("t3_still_busy", {31'd0, last_brs1}, 32'd1);

    // Test 4: write-back to x0 is consumed silently
    set_src(2, 5'd0, 32'h0000_1234); wb_valid = 3'b100;
    tick();
    check_eq("t4_grant", {29'd0, last_wb_ready}, 32'd4);
    check_eq("t4_we", {31'd0, rf_regwrite}, 32'd0);
    check_eq("t4_err", {31'd0, err_spurious}, 32'd0);
    wb_valid = 3'b000;

    // Test 5: spurious write-back to rd=9
    set_src(1, 5'd9, 32'h0000_0099); wb_valid = 3'b010;
    tick();
    check_eq("t5_err", {31'd0, err_spurious}, 32'd1);
    check_eq("t5_we", {31'd0, rf_regwrite}, 32'd1);
    check_eq("t5_rd", {27'd0, rf_rd}, 32'd9);
    wb_valid = 3'b000;
    tick(); tick();
    check_eq("t5_sticky", {31'd0, err_spurious}, 32'd1);

    // Test 6: reset with pending state and a write in flight
    alloc_valid = 1'b1;
    for (int r = 10; r <= 12; r++) begin
      alloc_rd = 5'(r);
      tick();
    end
    alloc_valid = 1'b0;
    set_src(0, 5'd10, 32'h0000_0AAA); wb_valid = 3'b001;
    tick();
    for (int s = 0; s < 3; s++) set_src(s, 5'd0, 32'h0000_0BB0 + 32'(s));
    wb_valid = 3'b111; rst_n = 1'b0;
    tick();
    check_eq("t6_wb_ready", {29'd0, last_wb_ready}, 32'd0);
    check_eq("t6_we", {31'd0, rf_regwrite}, 32'd0);
    check_eq("t6_pend", {26'd0, pend_cnt}, 32'd0);
    check_eq("t6_err", {31'd0, err_spurious}, 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("t6_ptr0", {29'd0, last_wb_ready}, 32'd1);
    wb_valid = 3'b000;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
